// File: rtl/usr_pkg.sv
// Shared mode codes, burst FSM state encoding and mode-class helper for the universal shift register.
// No logic of its own; no latency; no backpressure.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Only position-moving modes can be repeated by a burst.
  function automatic logic is_burst_mode(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst sequencer: latches mode/count, down-counts one step per cycle, drives busy/done and the step mode.
// Step mode is combinational from current state/inputs; done follows the last step by one cycle.
// A burst_start while busy is dropped, not queued.
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic [2:0]       step_mode,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [2:0]       mode_q, mode_nxt;
  logic             accept;

  assign accept = burst_start && is_burst_mode(mode) && (burst_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt_q  <= '0;
      mode_q <= MODE_HOLD;
    end else begin
      state  <= state_nxt;
      cnt_q  <= cnt_nxt;
      mode_q <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    mode_nxt  = mode_q;
    case (state)
      ST_SHIFT: begin
        cnt_nxt = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_nxt = ST_DONE;
      end
      default: begin
        // IDLE and DONE accept a new burst identically; the first step lands on this edge.
        state_nxt = ST_IDLE;
        if (burst_start) begin
          state_nxt = ST_DONE;
          cnt_nxt   = '0;
          if (accept) begin
            mode_nxt = mode;
            cnt_nxt  = burst_cnt - CNT_W'(1);
            if (burst_cnt > CNT_W'(1)) state_nxt = ST_SHIFT;
          end
        end
      end
    endcase
  end

  always_comb begin
    step_mode = mode;
    if (state == ST_SHIFT) step_mode = mode_q;
    else if (burst_start && !accept) step_mode = MODE_HOLD;
    busy = (state == ST_SHIFT);
    done = (state == ST_DONE);
  end

endmodule

// File: rtl/univ_shift_reg_burst.sv
// WIDTH-bit universal shift register with rotate/ASR and N-step bursts; USR_SERIAL_OUT_EN adds shifted-out bit outputs.
// Single steps take 1 clock; a burst of N updates data on N edges, done pulses in the following cycle.
// Inputs other than serial bits are ignored while busy; no stall toward the producer otherwise.
module univ_shift_reg_burst
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_in_left,
  input  logic             shift_in_right,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
`ifdef USR_SERIAL_OUT_EN
  ,
  output logic             shift_out_msb,
  output logic             shift_out_lsb
`endif
);

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] q, q_nxt;

  usr_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .burst_start (burst_start),
    .burst_cnt   (burst_cnt),
    .step_mode   (step_mode),
    .busy        (busy),
    .done        (done)
  );

  always_comb begin
    q_nxt = q;
    case (step_mode)
      MODE_SHL:  q_nxt = {q[WIDTH-2:0], shift_in_right};
      MODE_SHR:  q_nxt = {shift_in_left, q[WIDTH-1:1]};
      MODE_LOAD: q_nxt = data_in;
      MODE_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
      MODE_ASR:  q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
      default:   q_nxt = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= q_nxt;
  end

  assign data_out = q;

`ifdef USR_SERIAL_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_out_msb <= 1'b0;
      shift_out_lsb <= 1'b0;
    end else if (step_mode == MODE_SHL) begin
      shift_out_msb <= q[WIDTH-1];
    end else if ((step_mode == MODE_SHR) || (step_mode == MODE_ASR)) begin
      shift_out_lsb <= q[0];
    end
  end
`endif

endmodule
